// File: rtl/mips_prog_loader_if.sv
// Byte-stream input and memory write bus of the program loader.
// slave = loader side, master = host/memory side.
interface mips_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_prog_loader.sv
// Framed byte-stream loader: big-endian words into unified memory,
// holds the MIPS core while loading, releases it with a start pulse.
module mips_prog_loader #(
    parameter int         ADDR_W   = 10,
    parameter logic [7:0] HDR_LOAD = 8'hA5,
    parameter logic [7:0] HDR_RUN  = 8'hA6
) (
    input  logic                clk1,
    input  logic                rst_n,
    mips_prog_loader_if.slave   bus,
    output logic                cpu_hold,
    output logic                start_pulse,
    output logic                load_done,
    output logic                load_err
);
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO,
        DATA, CSUM, DONE, ERR
    } state_t;

    state_t            r_state;
    state_t            w_nstate;
    logic              r_run;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_cnt;
    logic [31:0]       r_asm;
    logic [1:0]        r_bcnt;
    logic [7:0]        r_csum;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_hold;
    logic              r_start;
    logic              r_done;
    logic              r_err;

    logic              w_acc;
    logic [7:0]        w_byte;
    logic              w_hdr;
    logic              w_last;

    assign w_acc  = bus.in_valid && r_in_ready;
    assign w_byte = bus.in_data;
    assign w_hdr  = (w_byte == HDR_LOAD) || (w_byte == HDR_RUN);
    // last byte of the last remaining word
    assign w_last = (r_bcnt == 2'd3) && (r_cnt == 16'd1);

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign cpu_hold      = r_hold;
    assign start_pulse   = r_start;
    assign load_done     = r_done;
    assign load_err      = r_err;

    // State register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nstate;
    end

    // Next-state decode, advancing only on accepted bytes
    always_comb begin
        w_nstate = r_state;
        if (w_acc) begin
            unique case (r_state)
                IDLE, DONE, ERR:
                    if (w_hdr) w_nstate = ADDR_HI;
                ADDR_HI: w_nstate = ADDR_LO;
                ADDR_LO: w_nstate = CNT_HI;
                CNT_HI:  w_nstate = CNT_LO;
                CNT_LO:
                    w_nstate = ({r_cnt[15:8], w_byte} != 16'd0)
                             ? DATA : CSUM;
                DATA:
                    if (w_last) w_nstate = CSUM;
                CSUM:
                    w_nstate = (w_byte == r_csum) ? DONE : ERR;
                default: w_nstate = IDLE;
            endcase
        end
    end

    // Datapath: field capture, word assembly, writes and status flags
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_bcnt      <= '0;
            r_csum      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hold      <= 1'b1;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready <= 1'b1;
            r_mem_we   <= 1'b0;
            r_start    <= 1'b0;
            if (w_acc) begin
                unique case (r_state)
                    IDLE, DONE, ERR: begin
                        if (w_hdr) begin
                            r_run  <= (w_byte == HDR_RUN);
                            r_done <= 1'b0;
                            r_err  <= 1'b0;
                            r_hold <= 1'b1;
                            r_csum <= '0;
                            r_bcnt <= '0;
                        end
                    end
                    ADDR_HI: begin
                        r_asm  <= {24'd0, w_byte};
                        r_csum <= r_csum ^ w_byte;
                    end
                    ADDR_LO: begin
                        r_addr <= ADDR_W'({r_asm[7:0], w_byte});
                        r_csum <= r_csum ^ w_byte;
                    end
                    CNT_HI: begin
                        r_cnt[15:8] <= w_byte;
                        r_csum      <= r_csum ^ w_byte;
                    end
                    CNT_LO: begin
                        r_cnt[7:0] <= w_byte;
                        r_csum     <= r_csum ^ w_byte;
                    end
                    DATA: begin
                        r_asm  <= {r_asm[23:0], w_byte};
                        r_csum <= r_csum ^ w_byte;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= {r_asm[23:0], w_byte};
                            r_addr      <= r_addr + ADDR_W'(1);
                            r_cnt       <= r_cnt - 16'd1;
                        end
                    end
                    CSUM: begin
                        if (w_byte == r_csum) begin
                            r_done <= 1'b1;
                            if (r_run) begin
                                r_hold  <= 1'b0;
                                r_start <= 1'b1;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: a frame-level model queues the
// expected writes and final status; a monitor checks every mem_we.
module tb_mips_prog_loader;
    localparam int         AW   = 10;
    localparam logic [7:0] HLD  = 8'hA5;
    localparam logic [7:0] HRUN = 8'hA6;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_hold, start_pulse, load_done, load_err;

    mips_prog_loader_if #(.ADDR_W(AW)) bus ();

    mips_prog_loader #(.ADDR_W(AW)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .start_pulse (start_pulse),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk1 = ~clk1;

    int  checks = 0;
    int  errors = 0;
    int  starts = 0;
    int  exp_starts = 0;
    bit  gaps = 0;
    bit  exp_done = 0;
    bit  exp_err = 0;
    bit  exp_hold = 1;
    wr_t expq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest expected write
    always @(negedge clk1) begin : mon
        wr_t e;
        if (rst_n && bus.mem_we) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr %h data %h want none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
                chk("wr_data", bus.mem_wdata, e.d);
            end
        end
        if (rst_n && start_pulse) begin
            starts++;
            chk("start_hold", 32'(cpu_hold), 32'd0);
            chk("start_done", 32'(load_done), 32'd1);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk1);
            end
        end
        while (!bus.in_ready) begin
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout got 0 want 1");
                return;
            end
            @(negedge clk1);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk1);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"}, 32'(load_done), 32'(exp_done));
        chk({tag, "_err"}, 32'(load_err), 32'(exp_err));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
        chk({tag, "_starts"}, 32'(starts), 32'(exp_starts));
        chk({tag, "_pending"}, 32'(expq.size()), 32'd0);
    endtask

    // Frame-level model: expected writes and status follow from the
    // frame contents alone.
    task automatic send_frame(input string tag, input logic [7:0] hdr,
                              input logic [15:0] addr,
                              input logic [31:0] words[$], input bit bad);
        logic [7:0]  cs;
        logic [15:0] cnt;
        wr_t         w;
        cnt = 16'(words.size());
        cs  = addr[15:8] ^ addr[7:0] ^ cnt[15:8] ^ cnt[7:0];
        foreach (words[i]) begin
            cs = cs ^ words[i][31:24] ^ words[i][23:16]
                    ^ words[i][15:8] ^ words[i][7:0];
            w.a = AW'(addr + 16'(i));
            w.d = words[i];
            expq.push_back(w);
        end
        if (bad) cs = cs ^ 8'h01;
        send_byte(hdr);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(cnt[15:8]);
        send_byte(cnt[7:0]);
        foreach (words[i]) begin
            send_byte(words[i][31:24]);
            send_byte(words[i][23:16]);
            send_byte(words[i][15:8]);
            send_byte(words[i][7:0]);
        end
        send_byte(cs);
        bus.in_valid = 1'b0;
        exp_done = !bad;
        exp_err  = bad;
        exp_hold = !(!bad && hdr == HRUN);
        if (!bad && hdr == HRUN) exp_starts++;
        repeat (3) @(negedge clk1);
        check_status(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_start"}, 32'(start_pulse), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog[$];
        logic [31:0] wq[$];
        logic [7:0]  hdr;
        logic [15:0] addr;
        bit          bad;
        int          n;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk1);
        check_reset_outputs("por");
        rst_n = 1'b1;
        #1 chk("por_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(negedge clk1);
        chk("ready_after_edge", 32'(bus.in_ready), 32'd1);

        prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                 32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
                 32'h3460fffc, 32'h2542fffe, 32'hdc000000};
        send_frame("prog", HLD, 16'h0000, prog, 1'b0);

        wq = '{32'h00000007};
        send_frame("run_ok", HRUN, 16'h00C8, wq, 1'b0);
        send_frame("run_bad", HRUN, 16'h00C8, wq, 1'b1);

        wq = '{32'hdeadbeef, 32'h01234567};
        send_frame("wrap", HLD, 16'h03FF, wq, 1'b0);

        wq = '{};
        send_frame("cnt0", HRUN, 16'h1234, wq, 1'b0);

        // reset in the middle of a word
        send_byte(HLD);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        exp_done = 0;
        exp_err  = 0;
        exp_hold = 1;
        repeat (4) @(negedge clk1);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'hC3);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk1);
        check_status("junk");
        wq = '{32'hcafef00d};
        send_frame("fresh", HLD, 16'h0010, wq, 1'b0);

        // random frames, each streamed back-to-back then with gaps
        for (int k = 0; k < 6; k++) begin
            hdr  = $urandom_range(0, 1) ? HRUN : HLD;
            addr = 16'($urandom);
            bad  = ($urandom_range(0, 3) == 0);
            n    = $urandom_range(1, 6);
            wq   = '{};
            for (int j = 0; j < n; j++) wq.push_back($urandom);
            gaps = 1'b0;
            send_frame("rnd_stream", hdr, addr, wq, bad);
            gaps = 1'b1;
            send_frame("rnd_gaps", hdr, addr, wq, bad);
        end
        gaps = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Byte-stream program/data loader feeding the 5-stage MIPS core's unified memory.
- Receives framed bytes (host or UART side), assembles big-endian 32-bit words and writes them sequentially into memory.
- Holds the core halted while loading, then releases it with a one-cycle start pulse.
- The start pulse drives PC=0, TAKEN_BRANCH=0 and HALTED=0 in the core.
- Counterpart of the instruction fetch/data read path: it is the writer that fills the memory the pipeline reads.

Parameters:
- ADDR_W, 10, memory word-address width; addresses wrap modulo 2^ADDR_W.
- HDR_LOAD, 8'hA5, header byte: load frame, keep core held afterwards.
- HDR_RUN, 8'hA6, header byte: load frame, release core on success.

Ports:
- clk1  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte strobe from the source.
- in_data  in  8  byte value.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  core must stay HALTED while high.
- start_pulse  out  1  one cycle: core sets PC=0, TAKEN_BRANCH=0, HALTED=0.
- load_done  out  1  last frame ended with a good checksum (sticky until next header).
- load_err  out  1  last frame had a bad checksum (sticky until next header).

Behaviour:
- Reset values:
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, start_pulse=0, load_done=0, load_err=0.
  - state=IDLE.
- in_ready=1 in every state from the first clk1 edge after reset release.
- A byte is accepted only on a clk1 edge with in_valid && in_ready.
- Frame format:
  - header, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT×4 data bytes (MSB first), then CSUM.
  - Address is truncated to ADDR_W bits. CNT is the word count (16 bits).
- Checksum: XOR of every byte after the header, up to and including the last data byte. The CSUM byte must equal it.
- FSM states: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR:
    - accepted HDR_LOAD or HDR_RUN -> ADDR_HI; latch the run flag; clear load_done/load_err; cpu_hold=1 on the next edge.
    - any other byte is discarded and the state is unchanged.
  - ADDR_HI -> ADDR_LO -> CNT_HI -> CNT_LO: one accepted byte each.
  - CNT_LO -> DATA if CNT≠0, else -> CSUM.
  - DATA: shift bytes into a 32-bit assembly register. On the 4th byte of a word:
    - the next cycle has mem_we=1, mem_addr=current address, mem_wdata=assembled word;
    - the address increments (wrapping) and the remaining count decrements.
    - When the count reaches 0 -> CSUM.
  - CSUM, match: -> DONE, load_done=1.
    - If the run flag is set: cpu_hold=0 and start_pulse=1 for exactly one cycle, both on the same edge as the DONE entry.
    - If HDR_LOAD: cpu_hold stays 1.
  - CSUM, mismatch: -> ERR, load_err=1, cpu_hold stays 1, no start_pulse. Words already written are not rolled back.
- Write latency: mem_we rises exactly 1 cycle after the edge accepting the word's 4th byte.
- Back-to-back bytes every cycle must be sustained without loss.
- Idle cycles (in_valid=0) may occur anywhere; there is no timeout.
- At most one mem_we per word; never write when CNT=0.
- Reset mid-frame: immediate return to reset values. Partial words are lost, and no write occurs for them.

Test Plan:
- HDR_LOAD, addr 0, cnt 11, words 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, dc000000 with correct CSUM:
  - 11 mem_we pulses at addr 0..10 with exactly these words;
  - load_done=1, cpu_hold=1, no start_pulse.
- Then HDR_RUN, bytes 00 C8 00 01 00 00 00 07, CSUM CE:
  - mem_we addr 200 data 00000007;
  - load_done=1, start_pulse high one cycle, cpu_hold=0;
  - the core then leaves Mem[198]=5040.
- Same run frame with CSUM CF: load_err=1, load_done=0, cpu_hold=1, start_pulse never asserted; Mem[200] still written with 7.
- Frame with addr 03FF, cnt 2 (ADDR_W=10): writes to 0x3FF then 0x000.
- Frame with cnt 0 and CSUM = XOR of the 4 header-field bytes: zero mem_we, load_done=1.
- Assert rst_n low after 2 data bytes, then release:
  - all outputs return to reset values, no mem_we;
  - leading non-header bytes are ignored;
  - a fresh frame then loads correctly.
- Random in_valid gaps vs continuous streaming: identical write sequence.
